// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle MIPS datapath: MULT/DIV encodings,
// funct codes used by the control unit, and the mult_div_unit state set.
package cpu_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   localparam logic [5:0] FUNCT_MULT = 6'h18;
   localparam logic [5:0] FUNCT_DIV  = 6'h1a;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_MULT_RUN = 3'd1,
      S_DIV_RUN  = 3'd2,
      S_FIX      = 3'd3,
      S_DONE     = 3'd4,
      S_DZ       = 3'd5
   } md_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step on unsigned magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep the difference if non-negative.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // rem_i < divisor_i, so the trial difference always fits WIDTH+1 bits signed.
   assign shifted = {rem_i, bit_i};
   assign trial   = shifted - {1'b0, divisor_i};
   assign q_o     = ~trial[WIDTH];
   assign rem_o   = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV unit: radix-2 Booth multiply and restoring divide,
// one bit per cycle, results committed to HI/LO with a done/div0 handshake.
module mult_div_unit
   import cpu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset_in,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div0
);

   md_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               op_q, op_d;
   logic [2*WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   dvsr_q, dvsr_d;
   logic               negq_q, negq_d;
   logic               negr_q, negr_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, done_q, div0_q;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH:0]     booth_sum;
   logic [WIDTH-1:0]   step_rem;
   logic               step_q;
   logic               last_step;

   // 0x80000000 maps to itself, which is the correct unsigned magnitude.
   assign a_mag     = a[WIDTH-1] ? -a : a;
   assign b_mag     = b[WIDTH-1] ? -b : b;
   assign acc_hi    = acc_q[2*WIDTH:WIDTH+1];
   assign last_step = (cnt_q == CNT_W'(WIDTH-1));

   // Sum kept one bit wider so the most negative multiplicand cannot overflow.
   always_comb begin
      booth_sum = {acc_hi[WIDTH-1], acc_hi};
      case (acc_q[1:0])
         2'b01:   booth_sum = {acc_hi[WIDTH-1], acc_hi} + {mcand_q[WIDTH-1], mcand_q};
         2'b10:   booth_sum = {acc_hi[WIDTH-1], acc_hi} - {mcand_q[WIDTH-1], mcand_q};
         default: booth_sum = {acc_hi[WIDTH-1], acc_hi};
      endcase
   end

   div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_i     (rem_q),
      .divisor_i (dvsr_q),
      .bit_i     (quo_q[WIDTH-1]),
      .rem_o     (step_rem),
      .q_o       (step_q)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvsr_d  = dvsr_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d  = op;
               cnt_d = '0;
               if (op == OP_MULT) begin
                  mcand_d = a;
                  acc_d   = {{WIDTH{1'b0}}, b, 1'b0};
                  state_d = S_MULT_RUN;
               end else if (b == '0) begin
                  state_d = S_DZ;
               end else begin
                  dvsr_d  = b_mag;
                  quo_d   = a_mag;
                  rem_d   = '0;
                  negq_d  = a[WIDTH-1] ^ b[WIDTH-1];
                  negr_d  = a[WIDTH-1];
                  state_d = S_DIV_RUN;
               end
            end
         end
         S_MULT_RUN: begin
            acc_d = {booth_sum, acc_q[WIDTH:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step) state_d = S_FIX;
         end
         S_DIV_RUN: begin
            rem_d = step_rem;
            quo_d = {quo_q[WIDTH-2:0], step_q};
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step) state_d = S_FIX;
         end
         S_FIX: begin
            if (op_q == OP_MULT) begin
               hi_d = acc_q[2*WIDTH:WIDTH+1];
               lo_d = acc_q[WIDTH:1];
            end else begin
               lo_d = negq_q ? -quo_q : quo_q;
               hi_d = negr_q ? -rem_q : rem_q;
            end
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         S_DZ:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs are registered from the state, so they trail it by one cycle.
   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= 1'b0;
         acc_q   <= '0;
         mcand_q <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvsr_q  <= dvsr_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= (state_q == S_MULT_RUN) || (state_q == S_DIV_RUN) || (state_q == S_FIX);
         done_q  <= (state_q == S_DONE) || (state_q == S_DZ);
         div0_q  <= (state_q == S_DZ);
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = busy_q;
   assign done = done_q;
   assign div0 = div0_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, busy/done/div0 handshake,
// signed MULT/DIV corner cases, ignored start, and mid-operation reset.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset_in = 1'b0;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] hi, lo;
   logic        busy, done, div0;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk      (clk),
      .reset_in (reset_in),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .done     (done),
      .div0     (div0)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Drive at negedge; start is sampled at the following posedge (E0).
   // done is expected in the cycle after E34; inj>0 pulses a stray MULT start.
   task automatic run_op(input string tag, input logic o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [63:0] exp, input int inj);
      int nbusy, ndone;
      @(negedge clk);
      start = 1'b1; op = o; a = av; b = bv;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom;
      nbusy = 0; ndone = 0;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         if (k == inj) begin
            start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4;
         end else begin
            start = 1'b0;
         end
         if (busy !== 1'b1) nbusy++;
         if (done !== 1'b0) ndone++;
      end
      start = 1'b0;
      chk({tag, "_busy_gaps"}, 64'(nbusy), 64'd0);
      chk({tag, "_early_done"}, 64'(ndone), 64'd0);
      @(negedge clk);
      chk({tag, "_done"}, {63'd0, done}, 64'd1);
      chk({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
      chk({tag, "_div0"}, {63'd0, div0}, 64'd0);
      chk({tag, "_hilo"}, {hi, lo}, exp);
      @(negedge clk);
      chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
   endtask

   task automatic run_dz(input logic [63:0] prev);
      @(negedge clk);
      start = 1'b1; op = 1'b1; a = 32'd5; b = 32'd0;
      @(negedge clk);
      start = 1'b0;
      chk("dz_done_e0", {63'd0, done}, 64'd0);
      @(negedge clk);
      chk("dz_done", {63'd0, done}, 64'd1);
      chk("dz_div0", {63'd0, div0}, 64'd1);
      chk("dz_busy", {63'd0, busy}, 64'd0);
      chk("dz_hilo_kept", {hi, lo}, prev);
      @(negedge clk);
      chk("dz_pulse", {62'd0, done, div0}, 64'd0);
   endtask

   initial begin
      #2;
      chk("rst_hilo", {hi, lo}, 64'd0);
      chk("rst_ctl", {61'd0, busy, done, div0}, 64'd0);
      @(negedge clk);
      reset_in = 1'b1;

      run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 0);
      run_dz(64'hFFFF_FFFF_FFFF_FFEB);
      run_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
      run_op("mul_max_min", 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 0);
      run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
      run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0);
      run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 0);
      run_op("div_100_7", 1'b1, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 10);

      // Abort a MULT mid-flight; previous HI/LO (2,14) must clear at once.
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4;
      @(negedge clk);
      start = 1'b0;
      repeat (15) @(negedge clk);
      reset_in = 1'b0;
      #1;
      chk("abort_hilo", {hi, lo}, 64'd0);
      chk("abort_ctl", {61'd0, busy, done, div0}, 64'd0);
      @(negedge clk);
      reset_in = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_idle", {62'd0, busy, done}, 64'd0);

      run_op("mul_3_4", 1'b0, 32'd3, 32'd4, 64'd12, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
